// File: rtl/phy_pkg.sv
// Lane-level symbols and receiver state encoding.
// This package is shared by the transmitter, the receiver and the byte striping logic.
package phy_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    SYNC    = 2'd1,
    ALIGNED = 2'd2
  } rx_state_t;

  function automatic logic is_com(input logic [7:0] sym);
    return sym == COM_SYM;
  endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial lane in, byte stream out. The master drives the lane; the slave is the receiver.
// There is no backpressure: data_in is accepted every clock.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (output data_in, input data_out, valid_out, active);
  modport slave  (input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_paralelo_rx_shift.sv
// MSB-first 8-bit shift register. sr_next is the byte that includes the bit sampled this edge.
// It has zero latency on sr_next, one cycle on internal state, and no backpressure.
module sp_shift_reg8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] sr_next
);

  logic [7:0] sr;

  assign sr_next = {sr[6:0], data_in};

  always_ff @(posedge clk_32f) begin
    if (reset) sr <= 8'h00;
    else       sr <= sr_next;
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Lane deserializer that locks byte alignment on COM_COUNT aligned COM symbols and emits payload bytes.
// A byte is registered on the edge that samples its LSB and is held for 8 cycles. There is no backpressure.
import phy_pkg::*;

module serial_paralelo_rx #(
  parameter int unsigned COM_COUNT = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  lane
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  logic [7:0] sr_next;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  rx_state_t  state;
  logic       com_now;
  logic       boundary;

  sp_shift_reg8 u_shift (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (lane.data_in),
    .sr_next (sr_next)
  );

  assign com_now  = is_com(sr_next);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt        <= 3'd0;
      com_cnt        <= 4'd0;
      state          <= SEARCH;
      lane.data_out  <= 8'h00;
      lane.valid_out <= 1'b0;
      lane.active    <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      case (state)
        SEARCH: begin
          // A COM found at any bit offset defines the byte phase.
          if (com_now) begin
            bit_cnt <= 3'd0;
            com_cnt <= 4'd1;
            if (COM_TARGET == 4'd1) begin
              state       <= ALIGNED;
              lane.active <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          if (boundary) begin
            if (com_now) begin
              com_cnt <= com_cnt + 4'd1;
              if (com_cnt + 4'd1 == COM_TARGET) begin
                state       <= ALIGNED;
                lane.active <= 1'b1;
              end
            end else begin
              state   <= SEARCH;
              com_cnt <= 4'd0;
            end
          end
        end
        ALIGNED: begin
          if (boundary) begin
            if (com_now) begin
              lane.valid_out <= 1'b0;
            end else begin
              lane.data_out  <= sr_next;
              lane.valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state          <= SEARCH;
          com_cnt        <= 4'd0;
          lane.valid_out <= 1'b0;
          lane.active    <= 1'b0;
        end
      endcase
    end
  end

endmodule
